axi4l_param_regfile: RTL
========================

Name: axi4l_param_regfile

Overview:
- Parametrised AXI4-Lite slave register file; next generation of the fixed four-register test slave.
- Adds configurable register count, data width and byte strobes.
- Adds read-only status registers fed from fabric, per-register write pulses, and SLVERR on illegal accesses.
- Sits behind the block-design AXI interconnect; driven by the master VIP in the bench.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
NUM_RW, 4, number of read/write control registers (1..64).
NUM_RO, 2, number of read-only status registers (0..64).
ADDR_WIDTH, 8, AXI address width; must cover (NUM_RW+NUM_RO) words.
RST_VAL, 0, reset value of every RW register.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
reg_out  out  NUM_RW*DATA_WIDTH  RW register contents, register k at [k*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_RW  one-cycle strobe when register k is written
status_in  in  max(NUM_RO,1)*DATA_WIDTH  RO register sources

Behaviour:
- Reset (async assert, sync release) values: all READY/VALID low, BRESP/RRESP=00, RDATA=0, wr_pulse=0, RW registers=RST_VAL.
- Address decode: word index = addr[ADDR_LSB +: IDX_W], where ADDR_LSB=clog2(DATA_WIDTH/8) and IDX_W=clog2(NUM_RW+NUM_RO).
  - Low ADDR_LSB bits ignored.
  - Address bits above the index must be zero, otherwise the access is out of range.
- Write channel, FSM WR_IDLE -> WR_RESP:
  - In WR_IDLE, AWREADY and WREADY are each high until their own handshake; AW and W are captured independently into holding registers, in either order or in the same cycle.
  - The cycle after both are held: the register update happens, wr_pulse[k] asserts for one cycle, BVALID rises; state goes to WR_RESP.
  - AW/W READY stay low in WR_RESP.
  - BVALID and BRESP hold until BREADY; then return to WR_IDLE. Back-to-back writes are possible: one write per 3 cycles minimum.
  - Update is byte-wise: byte b is written only if WSTRB[b]=1. WSTRB=0 gives OKAY, no change, wr_pulse still asserts.
  - Index >= NUM_RW (RO or out of range): BRESP=10 (SLVERR), no register change, no wr_pulse.
- Read channel, FSM RD_IDLE -> RD_DATA:
  - ARREADY high in RD_IDLE.
  - On AR handshake, RDATA/RRESP are registered and RVALID rises the next cycle.
  - RO registers return status_in sampled in the AR handshake cycle.
  - Out-of-range index: RDATA=0, RRESP=10.
  - RVALID, RDATA and RRESP hold until RREADY, then return to RD_IDLE.
- Read and write FSMs are independent. A simultaneous read and write to the same RW register returns the pre-write value when the AR handshake precedes or coincides with the update cycle.
- Reset mid-transaction: immediately abandons both FSMs, clears holding registers and VALIDs; no partial write is committed.
- NUM_RO=0: status_in is unused and all indices >= NUM_RW are out of range.

Decomposition:
- Package axi4l_regfile_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the wr_state_t and rd_state_t enums;
  - a function apply_wstrb(old, data, strb).
- One sub-module, axi4l_addr_decode: combinational, maps an address to index, is_rw, is_ro and out_of_range. It is instantiated twice, once for AW and once for AR.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 1,2,3,4 all RRESP=00; reg_out matches; wr_pulse[0..3] pulse once each.
- Write 0xAABBCCDD to 0x0 with WSTRB=0101 over a prior 0x11223344 -> read 0x11BB33DD.
- status_in reg4=0xDEADBEEF, read 0x10 -> 0xDEADBEEF OKAY; write 0x10 -> BRESP=10, the read value is unchanged and no wr_pulse fires.
- Read 0x40 (out of range, defaults) -> RDATA=0, RRESP=10; write 0x40 -> BRESP=10.
- W presented 3 cycles before AW, and BREADY held low 5 cycles -> BVALID stays asserted, AWREADY/WREADY stay low until B completes, and the data commits exactly once.
- ARESETN pulsed low after the AW handshake but before W -> all outputs return to reset values; a subsequent read of 0x0 returns RST_VAL.

Source files
------------

// File: rtl/axi4l_regfile_pkg.sv
// Shared types, response codes and helpers for the parametrised AXI4-Lite register file.
package axi4l_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest supported data bus; narrower buses are zero-extended into the helper.
    localparam int unsigned MAX_DW = 64;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    function automatic logic [MAX_DW-1:0] apply_wstrb(input logic [MAX_DW-1:0]   old_val,
                                                      input logic [MAX_DW-1:0]   data,
                                                      input logic [MAX_DW/8-1:0] strb);
        logic [MAX_DW-1:0] res;
        res = old_val;
        for (int b = 0; b < MAX_DW / 8; b++) begin
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        end
        return res;
    endfunction

    // Index width, never zero so a single-register map still has a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4l_addr_decode.sv
// Combinational byte-address to register-index decoder with RW/RO/out-of-range flags.
module axi4l_addr_decode
    import axi4l_regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RW     = 4,
    parameter int unsigned NUM_RO     = 2
) (
    input  logic [ADDR_WIDTH-1:0]                    addr,
    output logic [idx_width(NUM_RW+NUM_RO)-1:0]      idx,
    output logic                                     is_rw,
    output logic                                     is_ro,
    output logic                                     out_of_range
);

    localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = idx_width(NUM_RW + NUM_RO);

    logic        upper_nz;
    logic        in_range;
    int unsigned idx_int;
    logic        unused_low;

    assign idx        = addr[ADDR_LSB +: IDX_W];
    assign idx_int    = 32'(idx);
    assign unused_low = ^addr[ADDR_LSB-1:0];

    always_comb begin
        upper_nz = 1'b0;
        for (int i = ADDR_LSB + IDX_W; i < ADDR_WIDTH; i++) upper_nz |= addr[i];
    end

    assign in_range     = !upper_nz && (idx_int < NUM_RW + NUM_RO);
    assign is_rw        = in_range && (idx_int < NUM_RW);
    assign is_ro        = in_range && (idx_int >= NUM_RW);
    assign out_of_range = !in_range;

endmodule

// File: rtl/axi4l_param_regfile.sv
// AXI4-Lite slave with NUM_RW byte-strobed control registers and NUM_RO fabric status registers.
module axi4l_param_regfile
    import axi4l_regfile_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_RW     = 4,
    parameter int unsigned           NUM_RO     = 2,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                                                  S_AXI_ACLK,
    input  logic                                                  S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]                                 S_AXI_AWADDR,
    input  logic [2:0]                                            S_AXI_AWPROT,
    input  logic                                                  S_AXI_AWVALID,
    output logic                                                  S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                                 S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                               S_AXI_WSTRB,
    input  logic                                                  S_AXI_WVALID,
    output logic                                                  S_AXI_WREADY,
    output logic [1:0]                                            S_AXI_BRESP,
    output logic                                                  S_AXI_BVALID,
    input  logic                                                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                                 S_AXI_ARADDR,
    input  logic [2:0]                                            S_AXI_ARPROT,
    input  logic                                                  S_AXI_ARVALID,
    output logic                                                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                                 S_AXI_RDATA,
    output logic [1:0]                                            S_AXI_RRESP,
    output logic                                                  S_AXI_RVALID,
    input  logic                                                  S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0]                          reg_out,
    output logic [NUM_RW-1:0]                                     wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0]     status_in
);

    localparam int unsigned IDX_W  = idx_width(NUM_RW + NUM_RO);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_RW];
    logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_RW-1:0]     wr_pulse_q;

    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  aw_is_rw, aw_is_ro, aw_oor;
    logic                  ar_is_rw, ar_is_ro, ar_oor;
    int unsigned           aw_idx_int, ar_idx_int;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_top;

    // Write decode works on the held address so AW may arrive before W.
    axi4l_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO)
    ) u_aw_decode (
        .addr         (awaddr_q),
        .idx          (aw_idx),
        .is_rw        (aw_is_rw),
        .is_ro        (aw_is_ro),
        .out_of_range (aw_oor)
    );

    axi4l_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO)
    ) u_ar_decode (
        .addr         (S_AXI_ARADDR),
        .idx          (ar_idx),
        .is_rw        (ar_is_rw),
        .is_ro        (ar_is_ro),
        .out_of_range (ar_oor)
    );

    assign aw_idx_int = 32'(aw_idx);
    assign ar_idx_int = 32'(ar_idx);
    assign unused_top = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_is_ro, aw_oor, ar_oor, status_in};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state   <= WR_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int unsigned k = 0; k < NUM_RW; k++) regs_q[k] <= RST_VAL;
        end else begin
            wr_pulse_q <= '0;
            unique case (wr_state)
                WR_IDLE: begin
                    if (aw_held && w_held) begin
                        for (int unsigned k = 0; k < NUM_RW; k++) begin
                            if (aw_is_rw && aw_idx_int == k) begin
                                regs_q[k]     <= DATA_WIDTH'(apply_wstrb(MAX_DW'(regs_q[k]),
                                                 MAX_DW'(wdata_q), (MAX_DW/8)'(wstrb_q)));
                                wr_pulse_q[k] <= 1'b1;
                            end
                        end
                        bresp_q  <= aw_is_rw ? RESP_OKAY : RESP_SLVERR;
                        bvalid_q <= 1'b1;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        wr_state <= WR_RESP;
                    end else begin
                        if (awready_q && S_AXI_AWVALID) begin
                            awaddr_q  <= S_AXI_AWADDR;
                            aw_held   <= 1'b1;
                            awready_q <= 1'b0;
                        end else if (!aw_held) begin
                            awready_q <= 1'b1;
                        end
                        if (wready_q && S_AXI_WVALID) begin
                            wdata_q  <= S_AXI_WDATA;
                            wstrb_q  <= S_AXI_WSTRB;
                            w_held   <= 1'b1;
                            wready_q <= 1'b0;
                        end else if (!w_held) begin
                            wready_q <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Status words sit directly above the RW block in the index space.
    always_comb begin
        rd_mux = '0;
        for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (ar_is_rw && ar_idx_int == k) rd_mux = regs_q[k];
        end
        for (int unsigned j = 0; j < NUM_RO; j++) begin
            if (ar_is_ro && ar_idx_int == NUM_RW + j) rd_mux = status_in[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (arready_q && S_AXI_ARVALID) begin
                        rdata_q   <= rd_mux;
                        rresp_q   <= (ar_is_rw || ar_is_ro) ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rd_state  <= RD_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned k = 0; k < NUM_RW; k++) reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

endmodule
